// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and sizing helpers for the divide unit
package riscv_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
  typedef enum logic [1:0] {DIV, DIVU, REM, REMU} div_op_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  function automatic int div_cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring divide step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The partial remainder stays below the divisor, so its top bit only matters as an overflow guard.
  assign shifted = {rem_in[WIDTH-1:0], bit_in};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = rem_in[WIDTH] | (shifted >= {1'b0, divisor});
  assign rem_out = q_bit ? diff : shifted;

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle RV32M DIV/DIVU/REM/REMU unit
// DIV_EARLY_SPECIAL_EN: divide-by-zero and overflow skip CALC and finish one cycle after accept.
module div_unit
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic             div_sel_div,
  input  logic             div_sel_divu,
  input  logic             div_sel_rem,
  input  logic             div_sel_remu,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = div_cnt_width(WIDTH);
`ifdef DIV_EARLY_SPECIAL_EN
  localparam bit EARLY_SPECIAL = 1'b1;
`else
  localparam bit EARLY_SPECIAL = 1'b0;
`endif

  div_state_t       state, state_nx;
  div_op_t          op_q, op_in;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] quo, dvs, orig_a;
  logic             neg_q, neg_r, dz, ovf;

  logic             any_sel, signed_in, accept, dz_in, ovf_in, special_in;
  logic [WIDTH-1:0] abs_a, abs_b, q_fin;
  logic [WIDTH:0]   step_rem;
  logic             step_q;

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_comb begin
    op_in = REMU;
    if (div_sel_div)       op_in = DIV;
    else if (div_sel_divu) op_in = DIVU;
    else if (div_sel_rem)  op_in = REM;
  end

  assign any_sel    = div_sel_div | div_sel_divu | div_sel_rem | div_sel_remu;
  assign accept     = start && !busy && !kill && any_sel;
  assign signed_in  = (op_in == DIV) || (op_in == REM);
  assign abs_a      = (signed_in && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign abs_b      = (signed_in && operand_b[WIDTH-1]) ? -operand_b : operand_b;
  assign dz_in      = (operand_b == '0);
  assign ovf_in     = signed_in && (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&operand_b);
  assign special_in = dz_in || ovf_in;

  // The dividend register doubles as the quotient: MSBs shift out, quotient bits shift in.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (prem),
    .divisor (dvs),
    .bit_in  (quo[WIDTH-1]),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign q_fin = {quo[WIDTH-2:0], step_q};

  function automatic logic [WIDTH-1:0] final_mux(
    input div_op_t          op,
    input logic             dz_f,
    input logic             ovf_f,
    input logic             nq,
    input logic             nr,
    input logic [WIDTH-1:0] a_f,
    input logic [WIDTH-1:0] q_f,
    input logic [WIDTH-1:0] r_f
  );
    logic [WIDTH-1:0] qv, rv;
    if (dz_f) begin
      qv = '1;
      rv = a_f;
    end else if (ovf_f) begin
      qv = a_f;
      rv = '0;
    end else begin
      qv = nq ? -q_f : q_f;
      rv = nr ? -r_f : r_f;
    end
    return ((op == DIV) || (op == DIVU)) ? qv : rv;
  endfunction

  always_comb begin
    state_nx = state;
    if (kill) begin
      state_nx = IDLE;
    end else if (state == CALC) begin
      if (cnt == CW'(1)) state_nx = DONE;
    end else if (accept) begin
      state_nx = (EARLY_SPECIAL && special_in) ? DONE : CALC;
    end else begin
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= DIV;
      cnt    <= '0;
      prem   <= '0;
      quo    <= '0;
      dvs    <= '0;
      orig_a <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      ovf    <= 1'b0;
      result <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q   <= op_in;
        cnt    <= CW'(WIDTH);
        prem   <= '0;
        quo    <= abs_a;
        dvs    <= abs_b;
        orig_a <= operand_a;
        neg_q  <= signed_in && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]) && !dz_in;
        neg_r  <= signed_in && operand_a[WIDTH-1];
        dz     <= dz_in;
        ovf    <= ovf_in;
        if (EARLY_SPECIAL && special_in)
          result <= final_mux(op_in, dz_in, ovf_in, 1'b0, 1'b0, operand_a, '0, '0);
      end else if (state == CALC && !kill) begin
        prem <= step_rem;
        quo  <= q_fin;
        cnt  <= cnt - CW'(1);
        if (cnt == CW'(1))
          result <= final_mux(op_q, dz, ovf, neg_q, neg_r, orig_a, q_fin, step_rem[WIDTH-1:0]);
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit (vector table plus scoreboard)
module tb_div_unit;

  localparam int W = 32;
`ifdef DIV_EARLY_SPECIAL_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int OP_DIV = 0, OP_DIVU = 1, OP_REM = 2, OP_REMU = 3;
  localparam int NV = 18;

  logic         clk = 1'b0;
  logic         rst, start, kill;
  logic         s_div, s_divu, s_rem, s_remu;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] result;

  typedef struct {
    int           op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    bit           special;
  } vec_t;

  vec_t         vecs[NV];
  logic [W-1:0] sb[$];
  int           n_cmp = 0;
  int           n_fail = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .kill         (kill),
    .div_sel_div  (s_div),
    .div_sel_divu (s_divu),
    .div_sel_rem  (s_rem),
    .div_sel_remu (s_remu),
    .operand_a    (a),
    .operand_b    (b),
    .busy         (busy),
    .done         (done),
    .result       (result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int op, input logic [W-1:0] x, input logic [W-1:0] y);
    start  = 1'b1;
    s_div  = (op == OP_DIV);
    s_divu = (op == OP_DIVU);
    s_rem  = (op == OP_REM);
    s_remu = (op == OP_REMU);
    a      = x;
    b      = y;
  endtask

  task automatic release_in();
    start  = 1'b0;
    s_div  = 1'b0;
    s_divu = 1'b0;
    s_rem  = 1'b0;
    s_remu = 1'b0;
  endtask

  // Called just after the accept edge (cycle 1); returns the cycle in which done was seen.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic pop_check(input string name);
    logic [W-1:0] e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got 0x%08h", name, result);
    end else begin
      e = sb.pop_front();
      check(name, result, e);
    end
  endtask

  task automatic run_vec(input int i);
    int lat;
    bit bok;
    int exp_lat;
    drive(vecs[i].op, vecs[i].a, vecs[i].b);
    sb.push_back(vecs[i].exp);
    tick();
    release_in();
    wait_done(lat, bok);
    exp_lat = (EARLY && vecs[i].special) ? 1 : W + 1;
    check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat));
    check($sformatf("vec%0d_busy_calc", i), 32'(bok), 32'd1);
    if (done) begin
      check($sformatf("vec%0d_busy_at_done", i), 32'(busy), 32'd0);
      pop_check($sformatf("vec%0d_result", i));
    end else begin
      void'(sb.pop_front());
    end
    tick();
  endtask

  initial begin
    int  lat;
    bit  bok;
    bit  saw_done;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,        32'd14,         1'b0};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,        32'd2,          1'b0};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,  1'b0};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF,  1'b0};
    vecs[4]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE, 32'd1,         1'b0};
    vecs[5]  = '{OP_DIV,  32'd5,          32'd0,        32'hFFFF_FFFF,  1'b1};
    vecs[6]  = '{OP_REM,  32'd5,          32'd0,        32'd5,          1'b1};
    vecs[7]  = '{OP_DIVU, 32'd0,          32'd0,        32'hFFFF_FFFF,  1'b1};
    vecs[8]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[9]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1};
    vecs[10] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF,  1'b0};
    vecs[11] = '{OP_REMU, 32'hFFFF_FFFF,  32'd16,       32'd15,         1'b0};
    vecs[12] = '{OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        1'b0};
    vecs[13] = '{OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0};
    vecs[14] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
    vecs[15] = '{OP_REMU, 32'd5,          32'd0,        32'd5,          1'b1};
    vecs[16] = '{OP_REM,  32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFB,  1'b1};
    vecs[17] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0};

    rst = 1'b1;
    kill = 1'b0;
    a = '0;
    b = '0;
    release_in();
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) run_vec(i);

    // kill in CALC cycle 10: result keeps the previous 14
    run_vec(0);
    drive(OP_DIV, 32'd1000, 32'd3);
    tick();
    release_in();
    for (int c = 1; c < 10; c++) tick();
    check("kill_busy_before", 32'(busy), 32'd1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_busy_after", 32'(busy), 32'd0);
    check("kill_done_after", 32'(done), 32'd0);
    check("kill_result_held", result, 32'd14);
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check("kill_no_done", 32'(saw_done), 32'd0);

    drive(OP_DIV, 32'd1000, 32'd3);
    kill = 1'b1;
    tick();
    release_in();
    kill = 1'b0;
    check("kill_start_busy", 32'(busy), 32'd0);
    check("kill_start_done", 32'(done), 32'd0);

    drive(OP_DIV, 32'd1000, 32'd3);
    s_div = 1'b0;
    tick();
    release_in();
    check("nosel_busy", 32'(busy), 32'd0);
    tick();

    // back-to-back: second start issued during the first done cycle
    drive(OP_DIVU, 32'd100, 32'd7);
    sb.push_back(32'd14);
    tick();
    release_in();
    wait_done(lat, bok);
    check("b2b_first_latency", 32'(lat), 32'(W + 1));
    pop_check("b2b_first_result");
    drive(OP_REMU, 32'd100, 32'd7);
    sb.push_back(32'd2);
    tick();
    release_in();
    check("b2b_done_cleared", 32'(done), 32'd0);
    check("b2b_busy_resumed", 32'(busy), 32'd1);
    wait_done(lat, bok);
    check("b2b_second_latency", 32'(lat), 32'(W + 1));
    check("b2b_second_busy", 32'(bok), 32'd1);
    pop_check("b2b_second_result");
    tick();

    // reset mid-CALC clears everything
    drive(OP_DIVU, 32'd1000, 32'd7);
    tick();
    release_in();
    for (int c = 0; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'd0);
    rst = 1'b0;
    tick();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU) in the execute stage, beside the ALU. It takes the same operand_a/operand_b bus and one-hot select style as the ALU. Its result feeds the same EX/MEM result mux as the ALU and wins when `done` is high. The unit stalls the pipeline while busy.

## Interface
- WIDTH, 32: operand and result width. Must be even and at least 4.
- clk  in  1: clock. All state changes on the rising edge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: request. Sampled with the operands and selects.
- kill  in  1: pipeline flush. Aborts any operation.
- div_sel_div, div_sel_divu, div_sel_rem, div_sel_remu  in  1 each: operation select, one-hot.
- operand_a  in  WIDTH: dividend.
- operand_b  in  WIDTH: divisor.
- busy  out  1: operation in progress. The hazard unit stalls on this.
- done  out  1: single-cycle pulse. `result` is valid in this cycle.
- result  out  WIDTH: quotient or remainder. Held until the next accepted start.

## Operation
- States: IDLE, CALC, DONE.
- busy = (state == CALC).
- done = (state == DONE).
- Accept condition: start && !busy && !kill && (any select high). Accept is allowed in IDLE or DONE, so back-to-back operations work.
- On accept, latch:
  - |operand_a| and |operand_b|. Signed ops take the absolute value; unsigned ops pass the operand through.
  - Operation code.
  - Quotient-negate flag: signed op, sign bits differ, divisor nonzero.
  - Remainder-negate flag: signed op, dividend negative.
  - Special-case flags: divisor zero; overflow (operand_a == most-negative and operand_b == all-ones, signed only).
- Accept loads the counter with WIDTH and moves to CALC.
- CALC: radix-2 restoring step each cycle.
  - Partial remainder is WIDTH+1 bits. Shift in the next dividend MSB.
  - Trial-subtract the divisor. If non-negative, keep the difference and set quotient bit 1; otherwise restore.
  - Counter decrements each step. Counter reaching 1 → DONE.
- DONE entry, final result mux in priority order:
  1. Divide by zero: quotient = all-ones (DIV and DIVU); remainder = original operand_a.
  2. Overflow: quotient = operand_a (most-negative); remainder = 0.
  3. Otherwise: conditionally negate quotient or remainder per the flags.
- Special-case results are produced whether or not the macro below is defined.
- DONE: one cycle, then IDLE unless a new accept happens.
- Select priority if several are high: div > divu > rem > remu. Start with no select high is ignored.
- kill: next state IDLE from any state. done is not asserted, result is unchanged. kill beats start in the same cycle.
- rst: state IDLE, busy 0, done 0, result 0, internal registers 0. Applies mid-operation too.

## Timing
- Accept in cycle 0.
- Normal case: CALC in cycles 1..WIDTH; done = 1 in cycle WIDTH+1. Total latency WIDTH+1 (33 at WIDTH=32).
- busy is registered. It goes high the cycle after accept; the hazard unit covers cycle 0 itself from start.
- result is registered and changes only on DONE entry.
- Back-to-back: start during DONE is accepted. done is high for one cycle, then CALC resumes.

## Configuration
- DIV_EARLY_SPECIAL_EN defined: divide-by-zero and overflow go from accept straight to DONE. done is asserted in cycle 1, busy never rises.
- Not defined: special cases run the full WIDTH-step CALC. The final mux still produces the mandated values.
- Results are identical either way; only latency differs.

## Structure
- Shared package `riscv_pkg`:
  - `div_state_t` enum (IDLE, CALC, DONE).
  - `div_op_t` enum (DIV, DIVU, REM, REMU).
  - Constant for the counter width, $clog2(WIDTH+1).
- One sub-module, `div_step`: combinational single restoring step. Takes partial remainder, divisor and incoming bit; returns the next partial remainder and the quotient bit.
- FSM, sign handling and result mux stay in `div_unit`.

## Test plan
- DIVU 100 / 7, then REMU 100 / 7 → results 14 and 2. done in cycle 33 after accept; busy high cycles 1–32.
- DIV -7 / 2 → -3 (0xFFFFFFFD). REM -7 / 2 → -1. REM 7 / -2 → 1.
- DIV 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5; DIVU 0 / 0 → 0xFFFFFFFF. done in cycle 1 with macro, cycle 33 without.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- kill in cycle 10 of CALC → IDLE next cycle, no done pulse, result keeps its previous value. Then start with kill high in the same cycle → not accepted.
- rst asserted mid-CALC → busy, done and result all 0 next cycle. Back-to-back start during the DONE cycle → second done exactly 33 cycles later.
